// File: rtl/freq_meter_pkg.sv
// Shared constants and state encoding for the frequency meter.
package freq_meter_pkg;

  localparam int F_CLK_DEF = 25000000;
  localparam int CNT_W_DEF = 32;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

endpackage

// File: rtl/freq_meter_sync_edge_detect.sv
// Two-flop synchronizer plus registered rising-edge detector for an async input.
// A rising edge on d shows up on rise for one clk cycle, three cycles later.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync1 <= d;
      sync2 <= sync1;
      prev  <= sync2;
      rise  <= sync2 & ~prev;
    end
  end

endmodule

// File: rtl/freq_meter.sv
// Gated frequency counter: counts rising edges of sig_in over GATE_CYCLES clk
// cycles and publishes the count (saturating) with a one-cycle valid strobe.
//
// state   | meaning
// IDLE    | en low; counters held at 0, freq/overflow hold last result
// MEASURE | gate window running; window closes when gate_cnt hits GATE_CYCLES-1
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int F_CLK       = F_CLK_DEF,
  parameter int GATE_CYCLES = F_CLK,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq,
  output logic             freq_valid,
  output logic             overflow
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic             sat;
  logic             edge_p;
  logic [CNT_W-1:0] cnt_next;
  logic             sat_next;

  sync_edge_detect u_sync_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (sig_in),
    .rise (edge_p)
  );

  // sat marks an edge that arrived while the counter was already pinned at max
  always_comb begin
    cnt_next = edge_cnt;
    sat_next = sat;
    if (edge_p) begin
      if (edge_cnt == CNT_MAX) sat_next = 1'b1;
      else                     cnt_next = edge_cnt + CNT_W'(1);
    end
  end

  // The IDLE cycle on which en is first seen high is gate count 0 of the window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      sat        <= 1'b0;
      freq       <= '0;
      freq_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      freq_valid <= 1'b0;
      if (!en) begin
        state    <= IDLE;
        gate_cnt <= '0;
        edge_cnt <= '0;
        sat      <= 1'b0;
      end else begin
        state <= MEASURE;
        if (state == MEASURE && gate_cnt == GATE_LAST) begin
          freq       <= cnt_next;
          overflow   <= sat_next;
          freq_valid <= 1'b1;
          gate_cnt   <= '0;
          edge_cnt   <= '0;
          sat        <= 1'b0;
        end else begin
          gate_cnt <= gate_cnt + GW'(1);
          edge_cnt <= cnt_next;
          sat      <= sat_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: a 32-bit and a 4-bit instance share all inputs.
module tb_freq_meter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic        sig_in;
  logic        sig_level = 1'b0;
  logic        gen_sig   = 1'b0;
  int          sig_period = 10;
  int          ph = 0;

  logic [31:0] freq;
  logic        freq_valid;
  logic        overflow;
  logic [3:0]  freq4;
  logic        valid4;
  logic        ovf4;

  int passed = 0;
  int total  = 0;
  int n;
  logic seen;

  always #5 clk = ~clk;

  assign sig_in = (sig_period != 0) ? gen_sig : sig_level;

  freq_meter #(.F_CLK(1000), .GATE_CYCLES(100), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .freq(freq), .freq_valid(freq_valid), .overflow(overflow)
  );

  freq_meter #(.F_CLK(1000), .GATE_CYCLES(100), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .freq(freq4), .freq_valid(valid4), .overflow(ovf4)
  );

  // periodic stimulus: high for the first half of each period
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (sig_period != 0) begin
        ph = (ph + 1) % sig_period;
        gen_sig = (ph < sig_period / 2);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!freq_valid && cnt < 150);
  endtask

  initial begin
    // reset state
    tick();
    check("rst_freq", freq, 0);
    check("rst_valid", {31'd0, freq_valid}, 0);
    check("rst_ovf", {31'd0, overflow}, 0);
    check("rst_freq4", {28'd0, freq4}, 0);
    rst = 1'b1;
    ticks(20);

    // steady period-10 input
    en = 1'b1;
    wait_valid(n);
    check("first_strobe_lat", n, 100);
    check("p10_freq_w1", freq, 10);
    check("p10_ovf_w1", {31'd0, overflow}, 0);
    tick();
    check("strobe_one_cycle", {31'd0, freq_valid}, 0);
    wait_valid(n);
    check("strobe_period", n + 1, 100);
    check("p10_freq_w2", freq, 10);
    check("p10_freq4_w2", {28'd0, freq4}, 10);

    // en dropped at gate count 50 for 5 cycles
    ticks(50);
    en = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen = seen | freq_valid;
    end
    check("abort_no_valid", {31'd0, seen}, 0);
    check("abort_freq_hold", freq, 10);
    en = 1'b1;
    wait_valid(n);
    check("reraise_lat", n, 100);
    check("reraise_freq", freq, 10);

    // held low, then held high: a single rise counts once
    sig_period = 0;
    sig_level = 1'b0;
    wait_valid(n);
    wait_valid(n);
    check("held0_freq", freq, 0);
    sig_level = 1'b1;
    wait_valid(n);
    check("single_rise_freq", freq, 1);
    wait_valid(n);
    check("held1_freq", freq, 0);

    // window-boundary placement of a single rise
    sig_level = 1'b0;
    wait_valid(n);
    check("fall_freq", freq, 0);
    ticks(96);
    sig_level = 1'b1;
    wait_valid(n);
    check("edge_gate99_lat", n, 4);
    check("edge_gate99_freq", freq, 1);
    wait_valid(n);
    sig_level = 1'b0;
    wait_valid(n);
    check("after_fall_freq", freq, 0);
    ticks(97);
    sig_level = 1'b1;
    wait_valid(n);
    check("edge_gate0_lat", n, 3);
    check("edge_gate0_closing", freq, 0);
    wait_valid(n);
    check("edge_gate0_next", freq, 1);

    // saturation on the 4-bit instance
    sig_period = 4;
    wait_valid(n);
    wait_valid(n);
    check("p4_freq32", freq, 25);
    check("p4_ovf32", {31'd0, overflow}, 0);
    check("p4_freq4_sat", {28'd0, freq4}, 15);
    check("p4_ovf4", {31'd0, ovf4}, 1);
    sig_period = 10;
    wait_valid(n);
    wait_valid(n);
    check("p10_freq4_recover", {28'd0, freq4}, 10);
    check("p10_ovf4_clear", {31'd0, ovf4}, 0);

    // asynchronous reset mid-window
    ticks(60);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_freq", freq, 0);
    check("async_rst_valid", {31'd0, freq_valid}, 0);
    check("async_rst_ovf4", {31'd0, ovf4}, 0);
    tick();
    tick();
    rst = 1'b1;
    wait_valid(n);
    check("post_rst_lat", n, 100);
    wait_valid(n);
    check("post_rst_freq", freq, 10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 The block SHALL expose parameter F_CLK, default 25000000, meaning the clk frequency in Hz (documentation and default derivation only).
REQ-002 The block SHALL expose parameter GATE_CYCLES, default F_CLK, meaning the gate window length in clk cycles (1 s default, so the result reads in Hz).
REQ-003 The block SHALL expose parameter CNT_W, default 32, meaning the width of the edge counter and of the result.
REQ-004 Port clk, input, 1, the single clock.
REQ-005 Port rst, input, 1, asynchronous, active-low reset.
REQ-006 Port en, input, 1, measurement enable; synchronous to clk.
REQ-007 Port sig_in, input, 1, signal under measurement; asynchronous to clk.
REQ-008 Port freq, output, CNT_W, rising-edge count of the last completed window.
REQ-009 Port freq_valid, output, 1, one-cycle strobe when freq updates.
REQ-010 Port overflow, output, 1, the last completed window saturated.

Function
REQ-011 sig_in SHALL pass through a 2-flop synchronizer, then a registered edge detector producing edge_p = sync2 & ~prev for one clk cycle per rising edge.
REQ-012 The FSM SHALL have two states: IDLE and MEASURE.
REQ-013 In IDLE, the gate counter and edge counter SHALL be held at 0, and freq/overflow SHALL hold their values.
REQ-014 IDLE SHALL go to MEASURE on the first cycle en=1; the window starts on that cycle (gate count 0).
REQ-015 In MEASURE, the gate counter SHALL increment every cycle, from 0 to GATE_CYCLES-1.
REQ-016 In MEASURE, the edge counter SHALL increment on every cycle with edge_p=1.
REQ-017 The edge counter SHALL saturate at 2^CNT_W-1 and set an internal sat flag; it SHALL never wrap.
REQ-018 On the terminal cycle (gate count = GATE_CYCLES-1), the next-cycle updates SHALL be:
- freq <= edge count, including an edge_p on that cycle, saturated;
- overflow <= sat;
- freq_valid = 1 for exactly one cycle;
- gate counter, edge counter and sat cleared;
- a new window starting back-to-back with no dead cycle.
REQ-019 MEASURE SHALL go to IDLE on any cycle with en=0.
- The partial window SHALL be discarded.
- No freq_valid SHALL be issued.
- freq and overflow SHALL keep their prior values.
REQ-020 If en falls on the terminal cycle, the window SHALL be discarded; en=0 takes priority.
REQ-021 First freq_valid after entering MEASURE: exactly GATE_CYCLES cycles later. Valid strobes then repeat every GATE_CYCLES cycles.
REQ-022 Pipeline latency from a sig_in rising edge to edge_p SHALL be 3 clk cycles.
- Edges within the last 3 cycles of a window are counted in the next window.
REQ-023 Measurable input: high and low phases each >= 2 clk periods; sig_in frequency <= F_CLK/4.
REQ-024 GATE_CYCLES SHALL be >= 2; the gate counter width SHALL be $clog2(GATE_CYCLES).

Reset
REQ-025 While rst=0, asynchronously:
- freq=0, freq_valid=0, overflow=0;
- FSM in IDLE;
- all counters, synchronizer and edge-detect flops = 0.
REQ-026 Reset asserted mid-window SHALL abort the window with no valid strobe.
REQ-027 Release of rst SHALL be synchronous to clk; the first window may begin on the first cycle after release if en=1.

Structure
REQ-028 Package freq_meter_pkg SHALL hold:
- default constants F_CLK_DEF=25000000 and CNT_W_DEF=32;
- the state typedef {IDLE, MEASURE}.
REQ-029 The synchronizer and edge detector SHALL be one sub-module, sync_edge_detect (ports: clk, rst, d, rise), reusable for other asynchronous inputs.

Verification
All benches use F_CLK=1000 and GATE_CYCLES=100 unless noted.
REQ-030 en=1, sig_in period 10 clk -> freq=10, overflow=0, freq_valid every 100 cycles, first strobe 100 cycles after en rise.
REQ-031 en=1, sig_in held 0, then held 1 -> freq=0 each window; a single rise contributes 1 only to its window.
REQ-032 CNT_W=4, sig_in period 4 clk -> 25 edges per window saturate; freq=15, overflow=1. Then period 10 clk -> freq=10, overflow=0.
REQ-033 en dropped at gate count 50 for 5 cycles, then re-raised -> no strobe for the aborted window, freq holds prior value; next strobe 100 cycles after re-raise.
REQ-034 Single sig_in rise placed so edge_p lands on gate count 99 -> counted in the closing window (freq=1); rise placed so edge_p lands on gate count 0 of the next window -> counted there.
REQ-035 rst=0 pulsed at gate count 60 -> freq=0, freq_valid=0, overflow=0 immediately, without waiting for clk; after release with en=1, first strobe 100 cycles later.
